// File: rtl/bin_para_bcd_seq.sv
// +----------------------------------------------------------------------------
// | bin_para_bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module bin_para_bcd_seq #(
  parameter int LARGURA   = 16,
  parameter int DIGITOS   = 5,
  parameter int COM_SINAL = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inicio,
  input  logic [LARGURA-1:0]     bin,
  output logic                   ocupado,
  output logic                   pronto,
  output logic [4*DIGITOS-1:0]   bcd,
  output logic                   negativo,
  output logic                   estouro
);

  localparam int BW = 4 * DIGITOS;
  localparam int CW = $clog2(LARGURA + 1);
  localparam logic [LARGURA-1:0] UM = LARGURA'(1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    DESLOCA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] mag_q, mag_d;
  logic [BW-1:0]      work_q, work_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sinal_q, sinal_d;
  logic               ovf_q, ovf_d;
  logic [BW-1:0]      bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic               est_q, est_d;
  logic               pronto_q, pronto_d;
  logic [BW-1:0]      ajuste;
  logic               neg_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= OCIOSO;
      mag_q    <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      sinal_q  <= 1'b0;
      ovf_q    <= 1'b0;
      bcd_q    <= '0;
      neg_q    <= 1'b0;
      est_q    <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      mag_q    <= mag_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      sinal_q  <= sinal_d;
      ovf_q    <= ovf_d;
      bcd_q    <= bcd_d;
      neg_q    <= neg_d;
      est_q    <= est_d;
      pronto_q <= pronto_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    mag_d    = mag_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    sinal_d  = sinal_q;
    ovf_d    = ovf_q;
    bcd_d    = bcd_q;
    neg_d    = neg_q;
    est_d    = est_q;
    pronto_d = 1'b0;
    neg_in   = (COM_SINAL != 0) && bin[LARGURA-1];

    ajuste = work_q;
    for (int i = 0; i < DIGITOS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) ajuste[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end

    case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          mag_d    = neg_in ? (~bin + UM) : bin;
          sinal_d  = neg_in;
          work_d   = '0;
          ovf_d    = 1'b0;
          cnt_d    = CW'(LARGURA);
          estado_d = DESLOCA;
        end
      end
      DESLOCA: begin
        // A carry out of the top digit is a multiple of 10^DIGITOS being dropped.
        work_d = {ajuste[BW-2:0], mag_q[LARGURA-1]};
        ovf_d  = ovf_q | ajuste[BW-1];
        mag_d  = {mag_q[LARGURA-2:0], 1'b0};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) estado_d = FIM;
      end
      FIM: begin
        bcd_d    = work_q;
        neg_d    = sinal_q;
        est_d    = ovf_q;
        pronto_d = 1'b1;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign ocupado  = (estado_q != OCIOSO);
  assign pronto   = pronto_q;
  assign bcd      = bcd_q;
  assign negativo = neg_q;
  assign estouro  = est_q;

endmodule

`default_nettype wire

// File: tb/tb_bin_para_bcd_seq.sv
// +----------------------------------------------------------------------------
// | tb_bin_para_bcd_seq: self-checking bench for bin_para_bcd_seq (three configurations)
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_bin_para_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        ini[3];
  logic [15:0] bv[3];
  logic        oc[3], pr[3], ng[3], es[3];
  logic [19:0] b0, b1;
  logic [7:0]  b2;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  int Lp[3] = '{16, 16, 8};
  int Dp[3] = '{5, 5, 2};
  int Sp[3] = '{1, 0, 0};

  always #5 clk = ~clk;

  bin_para_bcd_seq #(.LARGURA(16), .DIGITOS(5), .COM_SINAL(1)) u_def (
    .clk(clk), .rst(rst), .inicio(ini[0]), .bin(bv[0]),
    .ocupado(oc[0]), .pronto(pr[0]), .bcd(b0), .negativo(ng[0]), .estouro(es[0]));

  bin_para_bcd_seq #(.LARGURA(16), .DIGITOS(5), .COM_SINAL(0)) u_uns (
    .clk(clk), .rst(rst), .inicio(ini[1]), .bin(bv[1]),
    .ocupado(oc[1]), .pronto(pr[1]), .bcd(b1), .negativo(ng[1]), .estouro(es[1]));

  bin_para_bcd_seq #(.LARGURA(8), .DIGITOS(2), .COM_SINAL(0)) u_ovf (
    .clk(clk), .rst(rst), .inicio(ini[2]), .bin(bv[2][7:0]),
    .ocupado(oc[2]), .pronto(pr[2]), .bcd(b2), .negativo(ng[2]), .estouro(es[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference conversion by plain arithmetic: magnitude, mod 10^D, decimal digits.
  function automatic void conv(input int i, input logic [15:0] b,
                               output bit neg, output bit est, output logic [19:0] r);
    longint v, mag, lim;
    v   = longint'(b) & ((64'd1 << Lp[i]) - 1);
    neg = (Sp[i] != 0) && (((v >> (Lp[i] - 1)) & 1) != 0);
    mag = neg ? ((64'd1 << Lp[i]) - v) : v;
    lim = 1;
    for (int k = 0; k < Dp[i]; k++) lim = lim * 10;
    est = (mag >= lim);
    mag = mag % lim;
    r   = '0;
    for (int k = 0; k < Dp[i]; k++) begin
      r[4*k +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
  endfunction

  int          cd[3];
  bit          mb[3], mp[3], mn[3], me[3], pn[3], pe[3];
  logic [19:0] mbcd[3], pb[3];

  // Cycle-level model: accepted start -> busy for LARGURA+1 edges, then one pronto cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        cd[i] = 0; mb[i] = 0; mp[i] = 0; mn[i] = 0; me[i] = 0; mbcd[i] = '0;
      end else begin
        mp[i] = 0;
        if (mb[i]) begin
          cd[i] = cd[i] - 1;
          if (cd[i] == 0) begin
            mb[i] = 0; mp[i] = 1; mbcd[i] = pb[i]; mn[i] = pn[i]; me[i] = pe[i];
          end
        end else if (ini[i]) begin
          mb[i] = 1;
          cd[i] = Lp[i] + 1;
          conv(i, bv[i], pn[i], pe[i], pb[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        logic [19:0] act;
        act = (i == 0) ? b0 : (i == 1) ? b1 : {12'd0, b2};
        chk($sformatf("dut%0d_ocupado", i), 32'(oc[i]), 32'(mb[i]));
        chk($sformatf("dut%0d_pronto", i), 32'(pr[i]), 32'(mp[i]));
        chk($sformatf("dut%0d_bcd", i), 32'(act), 32'(mbcd[i]));
        chk($sformatf("dut%0d_negativo", i), 32'(ng[i]), 32'(mn[i]));
        chk($sformatf("dut%0d_estouro", i), 32'(es[i]), 32'(me[i]));
      end
    end
  end

  task automatic wait_pronto(input int i, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!pr[i] && lat < 40);
  endtask

  task automatic start_wait(input int i, input logic [15:0] v, output int lat);
    @(posedge clk); #2 bv[i] = v; ini[i] = 1'b1;
    @(posedge clk); #2 ini[i] = 1'b0;
    lat = 1;
    do begin
      @(posedge clk); #1;
      if (!pr[i]) lat++;
    end while (!pr[i] && lat < 40);
    lat = lat - 1 + 1;
  endtask

  int  lat;
  bit  seen;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin ini[i] = 1'b0; bv[i] = '0; end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    armed = 1'b1;
    #1;
    chk("reset_ocupado", 32'(oc[0]), 0);
    chk("reset_pronto", 32'(pr[0]), 0);
    chk("reset_bcd", 32'(b0), 0);
    chk("reset_negativo", 32'(ng[0]), 0);

    // 1234 with defaults: latency LARGURA+1
    start_wait(0, 16'd1234, lat);
    chk("lat_1234", lat, 17);
    chk("bcd_1234", 32'(b0), 32'h01234);
    chk("neg_1234", 32'(ng[0]), 0);
    chk("est_1234", 32'(es[0]), 0);

    // inicio held high, bin changed mid-run: restart every LARGURA+2 cycles
    @(posedge clk); #2 bv[0] = 16'd7; ini[0] = 1'b1;
    @(posedge clk); #2 bv[0] = 16'd9;
    wait_pronto(0, lat);
    chk("held_lat1", lat, 17);
    chk("held_bcd1", 32'(b0), 32'h00007);
    wait_pronto(0, lat);
    ini[0] = 1'b0;
    chk("held_period", lat, 18);
    chk("held_bcd2", 32'(b0), 32'h00009);
    repeat (3) @(posedge clk);

    start_wait(0, 16'hFFFF, lat);
    chk("bcd_ffff_signed", 32'(b0), 32'h00001);
    chk("neg_ffff_signed", 32'(ng[0]), 1);
    start_wait(0, 16'h8000, lat);
    chk("bcd_8000_signed", 32'(b0), 32'h32768);
    chk("neg_8000_signed", 32'(ng[0]), 1);

    start_wait(1, 16'hFFFF, lat);
    chk("bcd_ffff_unsigned", 32'(b1), 32'h65535);
    chk("neg_ffff_unsigned", 32'(ng[1]), 0);
    start_wait(1, 16'h0000, lat);
    chk("lat_zero", lat, 17);
    chk("bcd_zero", 32'(b1), 0);

    start_wait(2, 16'd200, lat);
    chk("lat_8bit", lat, 9);
    chk("est_200", 32'(es[2]), 1);
    chk("bcd_200", 32'(b2), 32'h00);
    start_wait(2, 16'd99, lat);
    chk("est_99", 32'(es[2]), 0);
    chk("bcd_99", 32'(b2), 32'h99);

    // reset on the 5th edge after acceptance aborts the conversion
    @(posedge clk); #2 bv[0] = 16'd1234; ini[0] = 1'b1;
    @(posedge clk); #2 ini[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_ocupado", 32'(oc[0]), 0);
    chk("abort_bcd", 32'(b0), 0);
    chk("abort_negativo", 32'(ng[0]), 0);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (pr[0]) seen = 1'b1;
    end
    chk("abort_no_pronto", 32'(seen), 0);
    start_wait(0, 16'd42, lat);
    chk("lat_42", lat, 17);
    chk("bcd_42", 32'(b0), 32'h00042);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
